// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: NUM_REGS word registers, independent AW/W capture, one B/R beat per request.
// Optional macro AXIL_REGFILE_PROT_CHECK_EN rejects writes whose AWPROT[0] is 0 (unprivileged).
module axi4_lite_slave_regfile #(
  parameter int                    DATA_WIDTH    = 32,
  parameter int                    ADDRESS_WIDTH = 32,
  parameter int                    NUM_REGS      = 8,
  parameter logic [DATA_WIDTH-1:0] RESET_VALUE   = '0
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDRESS_WIDTH-1:0]       AWADDR,
  input  logic [2:0]                     AWPROT,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDRESS_WIDTH-1:0]       ARADDR,
  input  logic [2:0]                     ARPROT,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q,
  output logic [NUM_REGS-1:0]            reg_wr_pulse,
  output logic                           w_state_dbg,
  output logic                           r_state_dbg
);

  localparam int STRB_W = DATA_WIDTH / 8;
  localparam int IDX_W  = $clog2(NUM_REGS);

  // Handshake rule: a beat transfers on a rising edge where VALID and READY are both 1;
  // VALID never waits on READY, and every READY here is a function of flops only.

  typedef enum logic { W_IDLE, W_RESP } w_state_t;
  typedef enum logic { R_IDLE, R_RESP } r_state_t;

  w_state_t              w_state;
  r_state_t              r_state;
  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic                  alive;
  logic                  aw_held;
  logic                  w_held;
  logic                  aw_oor;
  logic [IDX_W-1:0]      aw_idx;
  logic [DATA_WIDTH-1:0] w_data;
  logic [STRB_W-1:0]     w_strb;
  logic                  prot_ok;
  logic                  unused_ok;

  // alive keeps every READY low while reset is asserted without a reset-to-output path.
  assign AWREADY     = alive && !aw_held && !BVALID;
  assign WREADY      = alive && !w_held && !BVALID;
  assign ARREADY     = alive && !RVALID;
  assign w_state_dbg = (w_state == W_RESP);
  assign r_state_dbg = (r_state == R_RESP);

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg_q
    assign reg_q[g*DATA_WIDTH +: DATA_WIDTH] = regs[g];
  end

`ifdef AXIL_REGFILE_PROT_CHECK_EN
  logic aw_priv;
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn)              aw_priv <= 1'b0;
    else if (AWVALID && AWREADY) aw_priv <= AWPROT[0];
  end
  assign prot_ok   = aw_priv;
  assign unused_ok = ^{AWPROT[2:1], ARPROT, AWADDR[1:0], ARADDR[1:0]};
`else
  assign prot_ok   = 1'b1;
  assign unused_ok = ^{AWPROT, ARPROT, AWADDR[1:0], ARADDR[1:0]};
`endif

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      w_state      <= W_IDLE;
      alive        <= 1'b0;
      aw_held      <= 1'b0;
      w_held       <= 1'b0;
      aw_idx       <= '0;
      aw_oor       <= 1'b0;
      w_data       <= '0;
      w_strb       <= '0;
      BVALID       <= 1'b0;
      BRESP        <= 2'b00;
      reg_wr_pulse <= '0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VALUE;
    end else begin
      alive        <= 1'b1;
      reg_wr_pulse <= '0;
      if (AWVALID && AWREADY) begin
        aw_idx  <= AWADDR[IDX_W+1:2];
        aw_oor  <= (AWADDR >> (IDX_W + 2)) != '0;
        aw_held <= 1'b1;
      end
      if (WVALID && WREADY) begin
        w_data <= WDATA;
        w_strb <= WSTRB;
        w_held <= 1'b1;
      end
      case (w_state)
        W_IDLE: begin
          if (aw_held && w_held) begin
            if (!aw_oor && prot_ok) begin
              for (int b = 0; b < STRB_W; b++)
                if (w_strb[b]) regs[aw_idx][b*8 +: 8] <= w_data[b*8 +: 8];
              reg_wr_pulse[aw_idx] <= 1'b1;
              BRESP <= 2'b00;
            end else begin
              BRESP <= 2'b10;
            end
            BVALID  <= 1'b1;
            w_state <= W_RESP;
          end
        end
        W_RESP: begin
          // Held flags clear with the B beat, so the next AW/W lands a cycle later.
          if (BREADY) begin
            BVALID  <= 1'b0;
            aw_held <= 1'b0;
            w_held  <= 1'b0;
            w_state <= W_IDLE;
          end
        end
        default: w_state <= W_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      r_state <= R_IDLE;
      RVALID  <= 1'b0;
      RDATA   <= '0;
      RRESP   <= 2'b00;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ARVALID && ARREADY) begin
            // regs is sampled before any same-edge write commit lands.
            if ((ARADDR >> (IDX_W + 2)) != '0) begin
              RDATA <= '0;
              RRESP <= 2'b10;
            end else begin
              RDATA <= regs[ARADDR[IDX_W+1:2]];
              RRESP <= 2'b00;
            end
            RVALID  <= 1'b1;
            r_state <= R_RESP;
          end
        end
        R_RESP: begin
          if (RREADY) begin
            RVALID  <= 1'b0;
            r_state <= R_IDLE;
          end
        end
        default: r_state <= R_IDLE;
      endcase
    end
  end

endmodule
